// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle RV32-subset datapath: sequences fetch, decode,
// execute, memory and write-back, and traps on illegal opcodes or memory timeouts.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       mem_ready,
    input  logic       br_taken,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_src,
    output logic [2:0] dm_ctrl,
    output logic       ru_write,
    output logic [1:0] ru_data_src,
    output logic       instr_done,
    output logic       illegal,
    output logic       bus_err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_src;
        logic [2:0] dm_ctrl;
        logic       ru_write;
        logic [1:0] ru_data_src;
        logic       instr_done;
    } ctrl_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] WAIT_LIMIT = 4'd15;

    state_t     state_q;
    state_t     next_state;
    logic [3:0] wait_cnt;
    logic       illegal_q;
    logic       bus_err_q;
    logic       set_illegal;
    logic       set_bus_err;
    ctrl_t      ctrl;
    ctrl_t      ctrl_out;

    logic is_load, is_store, is_branch, is_jal, is_wb_only, supported;

    always_comb begin
        is_load    = (opcode == OP_LOAD);
        is_store   = (opcode == OP_STORE);
        is_branch  = (opcode == OP_BRANCH);
        is_jal     = (opcode == OP_JAL);
        is_wb_only = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LUI) || is_jal;
        supported  = is_wb_only || is_load || is_store || is_branch;
    end

    // NOTE: every signal driven here gets a default first so no path leaves one unassigned (no latches).
    always_comb begin
        next_state  = state_q;
        ctrl        = '0;
        set_illegal = 1'b0;
        set_bus_err = 1'b0;

        case (state_q)
            S_FETCH: begin
                ctrl.mem_req = 1'b1;
                if (mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    next_state    = S_DECODE;
                end else if (wait_cnt == WAIT_LIMIT) begin
                    next_state  = S_TRAP;
                    set_bus_err = 1'b1;
                end
            end

            S_DECODE: begin
                if (supported) begin
                    next_state = S_EXEC;
                end else begin
                    next_state  = S_TRAP;
                    set_illegal = 1'b1;
                end
            end

            S_EXEC: begin
                if (is_load || is_store) begin
                    next_state = S_MEM;
                end else if (is_branch) begin
                    ctrl.pc_write   = 1'b1;
                    ctrl.pc_src     = br_taken;
                    ctrl.instr_done = 1'b1;
                    next_state      = S_FETCH;
                end else if (is_wb_only) begin
                    next_state = S_WB;
                end else begin
                    // IR changed under us; treat it like a decode-time illegal opcode.
                    next_state  = S_TRAP;
                    set_illegal = 1'b1;
                end
            end

            S_MEM: begin
                ctrl.mem_req      = 1'b1;
                ctrl.mem_addr_src = 1'b1;
                ctrl.mem_we       = is_store;
                ctrl.dm_ctrl      = funct3;
                if (mem_ready) begin
                    if (is_store) begin
                        ctrl.pc_write   = 1'b1;
                        ctrl.instr_done = 1'b1;
                        next_state      = S_FETCH;
                    end else begin
                        next_state = S_WB;
                    end
                end else if (wait_cnt == WAIT_LIMIT) begin
                    next_state  = S_TRAP;
                    set_bus_err = 1'b1;
                end
            end

            S_WB: begin
                ctrl.ru_write    = 1'b1;
                ctrl.pc_write    = 1'b1;
                ctrl.instr_done  = 1'b1;
                ctrl.pc_src      = is_jal;
                ctrl.ru_data_src = is_load ? 2'b01 : (is_jal ? 2'b10 : 2'b00);
                next_state       = S_FETCH;
            end

            S_TRAP: next_state = S_TRAP;

            default: next_state = S_TRAP;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            wait_cnt  <= 4'd0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q <= next_state;
            if (set_illegal) illegal_q <= 1'b1;
            if (set_bus_err) bus_err_q <= 1'b1;
            if ((next_state != state_q) && ((next_state == S_FETCH) || (next_state == S_MEM))) begin
                wait_cnt <= 4'd0;
            end else if (ctrl.mem_req && !mem_ready) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end
    end

    // While reset is held every strobe is forced low so an aborted instruction commits nothing.
    always_comb begin
        ctrl_out = rst_n ? ctrl : '0;
    end

    assign ir_write     = ctrl_out.ir_write;
    assign pc_write     = ctrl_out.pc_write;
    assign pc_src       = ctrl_out.pc_src;
    assign mem_req      = ctrl_out.mem_req;
    assign mem_we       = ctrl_out.mem_we;
    assign mem_addr_src = ctrl_out.mem_addr_src;
    assign dm_ctrl      = ctrl_out.dm_ctrl;
    assign ru_write     = ctrl_out.ru_write;
    assign ru_data_src  = ctrl_out.ru_data_src;
    assign instr_done   = ctrl_out.instr_done;
    assign illegal      = rst_n & illegal_q;
    assign bus_err      = rst_n & bus_err_q;
    assign state        = state_q;

endmodule
